// File: rtl/maze_mem_arbiter_pkg.sv
// Shared types and widths for the maze memory arbiter: coordinate/data widths,
// arbiter state encoding and the {y,x} cell address helper.
package maze_arb_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned DATA_W  = 1;
  localparam int unsigned ADDR_W  = 2 * COORD_W;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Bus bundle between the two maze requesters, the arbiter and the maze RAM.
// master = requesters plus RAM (environment side), slave = the arbiter.
interface maze_mem_arbiter_if;
  import maze_arb_pkg::*;

  logic                r0_req;
  logic                r0_we;
  logic [COORD_W-1:0]  r0_x;
  logic [COORD_W-1:0]  r0_y;
  logic [DATA_W-1:0]   r0_wdata;
  logic                r0_gnt;
  logic                r0_rvalid;
  logic [DATA_W-1:0]   r0_rdata;

  logic                r1_req;
  logic                r1_we;
  logic [COORD_W-1:0]  r1_x;
  logic [COORD_W-1:0]  r1_y;
  logic [DATA_W-1:0]   r1_wdata;
  logic                r1_gnt;
  logic                r1_rvalid;
  logic [DATA_W-1:0]   r1_rdata;
  logic                r1_lock;

  logic                locked;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output r0_req, r0_we, r0_x, r0_y, r0_wdata,
    output r1_req, r1_we, r1_x, r1_y, r1_wdata, r1_lock,
    output mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  locked,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  r0_req, r0_we, r0_x, r0_y, r0_wdata,
    input  r1_req, r1_we, r1_x, r1_y, r1_wdata, r1_lock,
    input  mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output locked,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/maze_mem_arbiter_pick.sv
// Two-way combinational picker returning a one-hot grant (bit 0 = port 0).
// Ties go to the port not granted last when rr_en_i is set, else to port 0.
module maze_arb_pick (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  input  logic       rr_en_i,
  output logic [1:0] gnt_c_o
);

  always_comb begin
    gnt_c_o = 2'b00;
    if (req0_i && req1_i) begin
      // last_i = 1 means port 1 was granted most recently
      gnt_c_o = (rr_en_i && !last_i) ? 2'b10 : 2'b01;
    end else if (req0_i) begin
      gnt_c_o = 2'b01;
    end else if (req1_i) begin
      gnt_c_o = 2'b10;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze RAM between the rat datapath (port 0) and the host
// (port 1, with bulk-load lock). Define MAZE_ARB_RR_EN for round-robin tie-break.
module maze_mem_arbiter (
  input  logic             CLK,
  input  logic             RST,
  maze_mem_arbiter_if.slave bus
);
  import maze_arb_pkg::*;

  arb_state_e  state_q, state_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        gnt0_c, gnt1_c;
  logic [1:0]  pick_c;
  logic        last_w;
  logic        rr_en_w;
  logic        rvalid0_w, rvalid1_w;

`ifdef MAZE_ARB_RR_EN
  logic last_q, last_d;

  assign rr_en_w = 1'b1;
  assign last_w  = last_q;

  // Remembers which port won the most recent grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0_c || gnt1_c) begin
      last_d = gnt1_c;
    end
  end
`else
  assign rr_en_w = 1'b0;
  assign last_w  = 1'b1;
`endif

  maze_arb_pick u_pick (
    .req0_i  (bus.r0_req),
    .req1_i  (bus.r1_req),
    .last_i  (last_w),
    .rr_en_i (rr_en_w),
    .gnt_c_o (pick_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ARB;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    if (!RST) begin
      case (state_q)
        ARB: begin
          gnt0_c = pick_c[0];
          gnt1_c = pick_c[1];
          if (pick_c[1] && bus.r1_lock) begin
            state_d = LOCK1;
          end
        end
        LOCK1: begin
          // Dropping the lock hands this very cycle back to normal arbitration
          if (bus.r1_lock) begin
            gnt1_c = bus.r1_req;
          end else begin
            gnt0_c  = pick_c[0];
            gnt1_c  = pick_c[1];
            state_d = ARB;
          end
        end
        default: begin
          state_d = ARB;
        end
      endcase
    end
    rvalid0_d = gnt0_c & ~bus.r0_we;
    rvalid1_d = gnt1_c & ~bus.r1_we;
  end

  // Memory port mux: the granted requester drives address and data.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt0_c) begin
      bus.mem_we    = bus.r0_we;
      bus.mem_addr  = cell_addr(bus.r0_x, bus.r0_y);
      bus.mem_wdata = bus.r0_wdata;
    end else if (gnt1_c) begin
      bus.mem_we    = bus.r1_we;
      bus.mem_addr  = cell_addr(bus.r1_x, bus.r1_y);
      bus.mem_wdata = bus.r1_wdata;
    end
  end

  // Responses are suppressed while reset is held so nothing leaks across it.
  assign rvalid0_w = rvalid0_q & ~RST;
  assign rvalid1_w = rvalid1_q & ~RST;

  assign bus.mem_en    = gnt0_c | gnt1_c;
  assign bus.r0_gnt    = gnt0_c;
  assign bus.r1_gnt    = gnt1_c;
  assign bus.r0_rvalid = rvalid0_w;
  assign bus.r1_rvalid = rvalid1_w;
  assign bus.r0_rdata  = rvalid0_w ? bus.mem_rdata : '0;
  assign bus.r1_rdata  = rvalid1_w ? bus.mem_rdata : '0;
  assign bus.locked    = (state_q == LOCK1);

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: directed vector table plus randomized
// traffic checked against a cycle-level reference model and a behavioural RAM.
module tb_maze_mem_arbiter;
  import maze_arb_pkg::*;

`ifdef MAZE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit rst;
    bit q0; bit w0; int a0; bit d0;
    bit q1; bit w1; int a1; bit d1; bit lk;
    bit has;
    bit g0; bit g1; bit rv0; bit rd0; bit rv1; bit lkd;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  maze_mem_arbiter_if bus();

  maze_mem_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Behavioural synchronous-read maze RAM
  logic ram [256];
  logic rd_q = 1'b0;
  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata[0];
      else            rd_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;

  // Reference model state
  bit m_mem [256];
  bit m_lock, m_last, m_v0, m_d0, m_v1, m_d1;
  int checks, errors, last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst,
                              input bit q0, input bit w0, input int a0, input bit d0,
                              input bit q1, input bit w1, input int a1, input bit d1,
                              input bit lk);
    vec_t v;
    v.rst = rst;
    v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
    v.has = 1'b0;
    v.g0 = 1'b0; v.g1 = 1'b0; v.rv0 = 1'b0; v.rd0 = 1'b0; v.rv1 = 1'b0; v.lkd = 1'b0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input bit g0, input bit g1, input bit rv0,
                              input bit rd0, input bit rv1, input bit lkd);
    vec_t v = vi;
    v.has = 1'b1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.lkd = lkd;
    return v;
  endfunction

  // Which port the rules say gets this cycle: -1 none, 0, or 1
  function automatic int model_pick(input vec_t v);
    if (v.rst) return -1;
    if (m_lock && v.lk) return v.q1 ? 1 : -1;
    if (v.q0 && v.q1) return (RR && !m_last) ? 1 : 0;
    if (v.q0) return 0;
    if (v.q1) return 1;
    return -1;
  endfunction

  task automatic step(input vec_t v);
    int g;
    int a;
    bit we, wd, e_v0, e_v1;
    RST           = v.rst;
    bus.r0_req    = v.q0;
    bus.r0_we     = v.w0;
    bus.r0_x      = COORD_W'(v.a0 % 16);
    bus.r0_y      = COORD_W'(v.a0 / 16);
    bus.r0_wdata  = DATA_W'(v.d0);
    bus.r1_req    = v.q1;
    bus.r1_we     = v.w1;
    bus.r1_x      = COORD_W'(v.a1 % 16);
    bus.r1_y      = COORD_W'(v.a1 / 16);
    bus.r1_wdata  = DATA_W'(v.d1);
    bus.r1_lock   = v.lk;
    #1;
    g    = model_pick(v);
    e_v0 = !v.rst && m_v0;
    e_v1 = !v.rst && m_v1;
    chk("r0_gnt", 32'(bus.r0_gnt), 32'(g == 0));
    chk("r1_gnt", 32'(bus.r1_gnt), 32'(g == 1));
    chk("mem_en", 32'(bus.mem_en), 32'(g >= 0));
    if (g >= 0) begin
      a  = (g == 0) ? v.a0 : v.a1;
      we = (g == 0) ? v.w0 : v.w1;
      wd = (g == 0) ? v.d0 : v.d1;
      chk("mem_we", 32'(bus.mem_we), 32'(we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(a));
      if (we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
    end
    chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(e_v0));
    chk("r0_rdata", 32'(bus.r0_rdata), 32'(e_v0 && m_d0));
    chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(e_v1));
    chk("r1_rdata", 32'(bus.r1_rdata), 32'(e_v1 && m_d1));
    chk("locked", 32'(bus.locked), 32'(m_lock));
    if (v.has) begin
      chk("tbl_r0_gnt", 32'(bus.r0_gnt), 32'(v.g0));
      chk("tbl_r1_gnt", 32'(bus.r1_gnt), 32'(v.g1));
      chk("tbl_r0_rvalid", 32'(bus.r0_rvalid), 32'(v.rv0));
      chk("tbl_r0_rdata", 32'(bus.r0_rdata), 32'(v.rd0));
      chk("tbl_r1_rvalid", 32'(bus.r1_rvalid), 32'(v.rv1));
      chk("tbl_locked", 32'(bus.locked), 32'(v.lkd));
    end
    @(posedge CLK);
    #1;
    if (v.rst) begin
      m_lock = 1'b0; m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0;
    end else begin
      m_v0 = (g == 0) && !v.w0;
      m_d0 = m_mem[v.a0];
      m_v1 = (g == 1) && !v.w1;
      m_d1 = m_mem[v.a1];
      if (g == 0 && v.w0) m_mem[v.a0] = v.d0;
      if (g == 1 && v.w1) m_mem[v.a1] = v.d1;
      m_lock = m_lock ? v.lk : (g == 1 && v.lk);
      if (g >= 0) m_last = (g == 1);
    end
    last_g = g;
  endtask

  vec_t tbl[$];
  vec_t r;
  bit   h0, h1;

  initial begin
    checks = 0; errors = 0; last_g = -1;
    RST = 1'b1;
    bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.r1_lock = 1'b0;
    bus.r0_we = 1'b0; bus.r1_we = 1'b0;
    bus.r0_x = '0; bus.r0_y = '0; bus.r1_x = '0; bus.r1_y = '0;
    bus.r0_wdata = '0; bus.r1_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 1'($urandom_range(0, 1));
    end
    m_mem['h53] = 1'b1; m_mem['h10] = 1'b1; m_mem['h20] = 1'b0; m_mem['h77] = 1'b1;
    m_mem['hFF] = 1'b0; m_mem['h03] = 1'b0; m_mem['h04] = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = m_mem[i];
    m_lock = 1'b0; m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = 1'b0; m_d1 = 1'b0;

    // Unchecked power-on reset
    repeat (2) @(posedge CLK);
    #1;

    // Reset state
    tbl.push_back(ex(mk(1, 0,0,0,0, 0,0,0,0, 0), 0,0,0,0,0,0));
    tbl.push_back(ex(mk(1, 1,0,'h11,0, 1,0,'h22,0, 0), 0,0,0,0,0,0));
    // Single port-0 read of (3,5)
    tbl.push_back(ex(mk(0, 1,0,'h53,0, 0,0,0,0, 0), 1,0,0,0,0,0));
    tbl.push_back(ex(mk(0, 0,0,0,0, 0,0,0,0, 0), 0,0,1,1,0,0));
    // Continuous tie for 6 cycles after reset
    tbl.push_back(ex(mk(1, 0,0,0,0, 0,0,0,0, 0), 0,0,0,0,0,0));
    for (int i = 0; i < 6; i++) begin
      bit g0, g1, rv0, rv1;
      g0  = RR ? (i % 2 == 0) : 1'b1;
      g1  = RR ? (i % 2 == 1) : 1'b0;
      rv0 = RR ? (i % 2 == 1) : (i > 0);
      rv1 = RR ? (i > 0 && i % 2 == 0) : 1'b0;
      tbl.push_back(ex(mk(0, 1,0,'h10,0, 1,0,'h20,0, 0), g0, g1, rv0, rv0, rv1, 0));
    end
    tbl.push_back(ex(mk(0, 0,0,0,0, 0,0,0,0, 0), 0,0,!RR,!RR,RR,0));
    // Locked bulk load of row 0 while port 0 waits
    tbl.push_back(ex(mk(0, 0,0,0,0, 1,1,0,0, 1), 0,1,0,0,0,0));
    for (int i = 1; i < 16; i++) begin
      tbl.push_back(ex(mk(0, 1,0,'h77,0, 1,1,i,i % 2, 1), 0,1,0,0,0,1));
    end
    tbl.push_back(ex(mk(0, 1,0,'h77,0, 0,0,0,0, 0), 1,0,0,0,0,1));
    tbl.push_back(ex(mk(0, 0,0,0,0, 0,0,0,0, 0), 0,0,1,1,0,0));
    // Reset right after a read grant
    tbl.push_back(ex(mk(0, 1,0,'h53,0, 0,0,0,0, 0), 1,0,0,0,0,0));
    tbl.push_back(ex(mk(1, 1,0,'h53,0, 1,0,'h20,0, 0), 0,0,0,0,0,0));
    tbl.push_back(ex(mk(0, 1,0,'h53,0, 1,0,'h20,0, 0), 1,0,0,0,0,0));
    tbl.push_back(ex(mk(0, 0,0,0,0, 0,0,0,0, 0), 0,0,1,1,0,0));
    // Write (15,15) then read it back, then read two bulk-loaded cells
    tbl.push_back(ex(mk(0, 1,1,'hFF,1, 0,0,0,0, 0), 1,0,0,0,0,0));
    tbl.push_back(ex(mk(0, 1,0,'hFF,0, 0,0,0,0, 0), 1,0,0,0,0,0));
    tbl.push_back(ex(mk(0, 1,0,'h03,0, 0,0,0,0, 0), 1,0,1,1,0,0));
    tbl.push_back(ex(mk(0, 1,0,'h04,0, 0,0,0,0, 0), 1,0,1,1,0,0));
    tbl.push_back(ex(mk(0, 0,0,0,0, 0,0,0,0, 0), 0,0,1,0,0,0));

    foreach (tbl[i]) step(tbl[i]);

    // Randomized traffic obeying the hold-until-grant requester rule
    r  = mk(0, 0,0,0,0, 0,0,0,0, 0);
    h0 = 1'b0;
    h1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r.rst = ($urandom_range(0, 299) == 0);
      if (h0 && $urandom_range(0, 19) == 0) begin
        r.q0 = 1'b0; h0 = 1'b0;
      end else if (!h0) begin
        r.q0 = ($urandom_range(0, 2) != 0);
        r.w0 = 1'($urandom_range(0, 1));
        r.a0 = int'($urandom_range(0, 255));
        r.d0 = 1'($urandom_range(0, 1));
        h0   = r.q0;
      end
      if (h1 && $urandom_range(0, 19) == 0) begin
        r.q1 = 1'b0; h1 = 1'b0;
      end else if (!h1) begin
        r.q1 = ($urandom_range(0, 2) != 0);
        r.w1 = 1'($urandom_range(0, 1));
        r.a1 = int'($urandom_range(0, 255));
        r.d1 = 1'($urandom_range(0, 1));
        h1   = r.q1;
      end
      if ($urandom_range(0, 15) == 0) r.lk = !r.lk;
      step(r);
      if (last_g == 0 || r.rst) h0 = 1'b0;
      if (last_g == 1 || r.rst) h1 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
- Shares the single-port 16x16 one-bit maze memory between two requesters.
- Port 0 is the rat controller/datapath (RD/WR cell accesses while solving). Port 1 is the host side (maze loader / path inspector).
- Grants one access per cycle, drives the memory port, and returns read data with fixed one-cycle latency.
- Port 1 can lock the memory for uninterrupted bulk maze loading.

Parameters:
- COORD_W, 4, width of each X/Y coordinate; address = {y,x}, 2*COORD_W bits.
- DATA_W, 1, cell data width (1 = wall/open).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  synchronous active-high reset.
- r0_req  in  1  port 0 access request; held until r0_gnt.
- r0_we  in  1  port 0: 1 = write, 0 = read.
- r0_x  in  COORD_W  port 0 column.
- r0_y  in  COORD_W  port 0 row.
- r0_wdata  in  DATA_W  port 0 write data.
- r0_gnt  out  1  port 0 access issued this cycle.
- r0_rvalid  out  1  port 0 read data valid.
- r0_rdata  out  DATA_W  port 0 read data.
- r1_req, r1_we, r1_x, r1_y, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as port 0, for port 1.
- r1_lock  in  1  port 1 requests exclusive ownership.
- locked  out  1  arbiter is in LOCK1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  2*COORD_W  {y,x} of granted requester.
- mem_wdata  out  DATA_W  granted write data.
- mem_rdata  in  DATA_W  synchronous-read RAM data, valid cycle after mem_en&~mem_we.

Behaviour:
- Clock CLK, reset RST: one clock, synchronous, active-high.
- Reset values:
  - state = ARB; last = 1, so port 0 wins the first tie.
  - r0_rvalid = r1_rvalid = 0; rdata outputs 0; locked = 0.
  - gnt/mem_* are combinational and are 0 while RST is high.
- Requester rule: x, y, we and wdata stay stable while req=1 and gnt=0. Dropping req before grant is legal; the request is then withdrawn.
- gnt and mem_en/mem_we/mem_addr/mem_wdata are combinational from req, state and last in the same cycle. At most one gnt per cycle. mem_en = r0_gnt | r1_gnt.
- Writes complete at grant; no response is returned.
- Reads:
  - rN_rvalid is registered: it is 1 exactly the cycle after a read grant to port N.
  - rN_rdata = mem_rdata while rN_rvalid, else 0.
- Back-to-back grants to the same port on consecutive cycles are allowed; responses are pipelined.
- FSM ARB:
  - Only one req → grant it.
  - Both req → grant ~last (round-robin). last updates to the granted port on every grant.
  - Grant to port 1 with r1_lock=1 → next state LOCK1.
- FSM LOCK1:
  - locked=1.
  - r0 never granted; r1_req granted every cycle it is high.
  - r1_lock=0 → next state ARB, and no r1 grant that cycle unless r1_req (normal ARB rules apply in that cycle).
- Fairness in ARB: a held request is granted within 2 cycles.
- RST mid-read: a pending rvalid is cleared; no response is delivered after reset.
- Entering LOCK1 while a port 0 read is in flight: the r0_rvalid response is still delivered the next cycle.

Optional Feature:
- Macro MAZE_ARB_RR_EN.
- Defined: round-robin tie-break as above.
- Undefined: fixed priority, port 0 always wins ties. The last register is not implemented. LOCK1 behaviour is unchanged.

Decomposition:
- Package maze_arb_pkg holds:
  - COORD_W/DATA_W defaults;
  - state enum {ARB, LOCK1};
  - function cell_addr(x,y) returning {y,x}.
- One sub-module, maze_arb_pick: combinational two-way picker (req0, req1, last, rr enable) → one-hot grant.
- FSM, last register and rvalid pipeline stay in maze_mem_arbiter.

Test Plan:
- Reset, then r0 read (x=3, y=5) with mem_rdata=1 → r0_gnt and mem_addr=0x53 in cycle 0; r0_rvalid=1 and r0_rdata=1 in cycle 1; r1 outputs stay 0.
- Both ports request reads continuously for 6 cycles (RR enabled) → grants alternate 0,1,0,1,0,1, starting with port 0; each rvalid follows its grant by exactly 1 cycle.
- Same as above with MAZE_ARB_RR_EN undefined → port 0 granted all 6 cycles; r1_gnt=0 throughout.
- r1 writes cells (0,0)..(15,0) with r1_lock=1 while r0_req=1 → locked=1 from cycle 1; 16 consecutive r1 grants (mem_we=1, addr 0x00..0x0F); no r0_gnt. After r1_lock=0, r0 is granted within 1 cycle.
- r0 read granted, RST asserted the next cycle → r0_rvalid=0; state=ARB; the first tie afterwards goes to port 0.
- r0 write (x=15, y=15, wdata=1) followed by r0 read of the same cell → mem_we=1, addr=0xFF; then a read grant; r0_rdata=1 one cycle later.
